// File: rtl/apb_cmd_master.sv
// rtl/apb_cmd_master.sv - command/response to APB bridge with decode, wait states and timeout
//
// Accepts one command at a time, runs a single APB transfer to the slave
// picked by the top SEL_W address bits, and returns one response.
//
// Ports:
//   sys_clk, sys_rst        clock, asynchronous active-high reset
//   cmd_valid/cmd_ready     command handshake (ready only while IDLE)
//   cmd_write/addr/wdata/strb  command payload
//   rsp_valid/rsp_ready     response handshake (held until consumed)
//   rsp_rdata, rsp_err      read data; 00 ok, 01 slave error, 10 timeout, 11 decode error
//   psel, penable, pwrite, paddr, pwdata, pstrb   APB master signals
//   prdata, pready, pslverr per-slave APB return signals, slave i at slice i

module apb_cmd_master #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int NUM_SLV = 4,
   parameter int TIMEOUT = 16
) (
   input  logic                      sys_clk,
   input  logic                      sys_rst,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic                      cmd_write,
   input  logic [ADDR_W-1:0]         cmd_addr,
   input  logic [DATA_W-1:0]         cmd_wdata,
   input  logic [DATA_W/8-1:0]       cmd_strb,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [DATA_W-1:0]         rsp_rdata,
   output logic [1:0]                rsp_err,
   output logic [NUM_SLV-1:0]        psel,
   output logic                      penable,
   output logic                      pwrite,
   output logic [ADDR_W-1:0]         paddr,
   output logic [DATA_W-1:0]         pwdata,
   output logic [DATA_W/8-1:0]       pstrb,
   input  logic [NUM_SLV*DATA_W-1:0] prdata,
   input  logic [NUM_SLV-1:0]        pready,
   input  logic [NUM_SLV-1:0]        pslverr
);

   localparam int SEL_W  = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
   localparam int STRB_W = DATA_W / 8;
   localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [SEL_W-1:0]  cmd_idx;
   logic [SEL_W-1:0]  sel_idx;
   logic [CNT_W-1:0]  tcnt;
   logic              cmd_ok;
   logic              accept;
   logic              sel_ready;
   logic              sel_err;
   logic [DATA_W-1:0] sel_rdata;
   logic              tmo_hit;

   assign cmd_idx = cmd_addr[ADDR_W-1 -: SEL_W];
   // Non-power-of-two slave counts leave index codes with no slave behind them.
   assign cmd_ok  = (32'(cmd_idx) < 32'(NUM_SLV));
   assign accept  = cmd_valid && cmd_ready;

   // Only the selected slave's return signals are looked at.
   always_comb begin
      sel_ready = 1'b0;
      sel_err   = 1'b0;
      sel_rdata = '0;
      for (int i = 0; i < NUM_SLV; i++) begin
         if (sel_idx == SEL_W'(i)) begin
            sel_ready = pready[i];
            sel_err   = pslverr[i];
            sel_rdata = prdata[i*DATA_W +: DATA_W];
         end
      end
   end

   // Fires on the ACCESS cycle that would be the TIMEOUT-th one without pready.
   assign tmo_hit = (TIMEOUT != 0) && (tcnt == CNT_W'(TIMEOUT - 1));

   // State register
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; pready is checked before the timeout so it wins a tie.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = cmd_ok ? SETUP : RESP;
         SETUP:   state_nxt = ACCESS;
         ACCESS:  if (sel_ready || tmo_hit) state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output logic; cmd_ready is also gated by reset so it is low while reset is held.
   always_comb begin
      psel      = '0;
      penable   = 1'b0;
      cmd_ready = 1'b0;
      rsp_valid = 1'b0;
      case (state)
         IDLE: cmd_ready = !sys_rst;
         SETUP: begin
            for (int i = 0; i < NUM_SLV; i++) psel[i] = (sel_idx == SEL_W'(i));
         end
         ACCESS: begin
            for (int i = 0; i < NUM_SLV; i++) psel[i] = (sel_idx == SEL_W'(i));
            penable = 1'b1;
         end
         RESP: rsp_valid = 1'b1;
         default: ;
      endcase
   end

   // Bus-side registers and response capture
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         paddr     <= '0;
         pwrite    <= 1'b0;
         pwdata    <= '0;
         pstrb     <= '0;
         sel_idx   <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 2'b00;
         tcnt      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  if (cmd_ok) begin
                     paddr   <= cmd_addr;
                     pwrite  <= cmd_write;
                     pwdata  <= cmd_wdata;
                     pstrb   <= cmd_write ? cmd_strb : STRB_W'(0);
                     sel_idx <= cmd_idx;
                  end else begin
                     rsp_rdata <= '0;
                     rsp_err   <= 2'b11;
                  end
               end
            end
            ACCESS: begin
               if (sel_ready) begin
                  rsp_err   <= sel_err ? 2'b01 : 2'b00;
                  rsp_rdata <= (!pwrite && !sel_err) ? sel_rdata : '0;
                  tcnt      <= '0;
               end else if (tmo_hit) begin
                  rsp_err   <= 2'b10;
                  rsp_rdata <= '0;
                  tcnt      <= '0;
               end else if (TIMEOUT != 0) begin
                  tcnt <= tcnt + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_cmd_master.sv
// tb/tb_apb_cmd_master.sv - directed bench for apb_cmd_master (4-slave and 3-slave instances)

module tb_apb_cmd_master;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // Instance with defaults (4 slaves, TIMEOUT 16)
   logic         cmd_valid, cmd_ready, cmd_write;
   logic [31:0]  cmd_addr, cmd_wdata;
   logic [3:0]   cmd_strb;
   logic         rsp_valid, rsp_ready;
   logic [31:0]  rsp_rdata;
   logic [1:0]   rsp_err;
   logic [3:0]   psel;
   logic         penable, pwrite;
   logic [31:0]  paddr, pwdata;
   logic [3:0]   pstrb;
   logic [127:0] prdata;
   logic [3:0]   pready, pslverr;

   // Instance with 3 slaves
   logic         b_cmd_valid, b_cmd_ready, b_cmd_write;
   logic [31:0]  b_cmd_addr, b_cmd_wdata;
   logic [3:0]   b_cmd_strb;
   logic         b_rsp_valid, b_rsp_ready;
   logic [31:0]  b_rsp_rdata;
   logic [1:0]   b_rsp_err;
   logic [2:0]   b_psel;
   logic         b_penable, b_pwrite;
   logic [31:0]  b_paddr, b_pwdata;
   logic [3:0]   b_pstrb;
   logic [95:0]  b_prdata;
   logic [2:0]   b_pready, b_pslverr;
   logic         b_psel_seen = 1'b0;

   int n_checks = 0;
   int n_err    = 0;
   int count;

   apb_cmd_master #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(4), .TIMEOUT(16)) dut (
      .sys_clk(clk), .sys_rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
      .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready), .pslverr(pslverr)
   );

   apb_cmd_master #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(3), .TIMEOUT(16)) dut3 (
      .sys_clk(clk), .sys_rst(rst),
      .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_write(b_cmd_write),
      .cmd_addr(b_cmd_addr), .cmd_wdata(b_cmd_wdata), .cmd_strb(b_cmd_strb),
      .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
      .psel(b_psel), .penable(b_penable), .pwrite(b_pwrite), .paddr(b_paddr),
      .pwdata(b_pwdata), .pstrb(b_pstrb), .prdata(b_prdata), .pready(b_pready), .pslverr(b_pslverr)
   );

   always @(b_psel) if (|b_psel) b_psel_seen = 1'b1;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Offer a command at the current negedge; returns at the negedge after the accept edge.
   task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] st);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_strb = st;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic finish_rsp();
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("rsp_done", {rsp_valid, cmd_ready}, 2'b01);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_strb = 0;
      rsp_ready = 0; prdata = '0; pready = 4'hF; pslverr = 4'h0;
      b_cmd_valid = 0; b_cmd_write = 0; b_cmd_addr = 0; b_cmd_wdata = 0; b_cmd_strb = 0;
      b_rsp_ready = 0; b_prdata = '0; b_pready = 3'b111; b_pslverr = 3'b000;

      // Reset state
      @(posedge clk); #2;
      chk("rst_ctrl", {cmd_ready, rsp_valid, psel, penable, pwrite, pstrb, rsp_err}, '0);
      chk("rst_data", {paddr, pwdata, rsp_rdata}, '0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rel_ready", {cmd_ready, rsp_valid}, 2'b10);

      // Zero-wait write to slave 0
      issue(1'b1, 32'h0000_0004, 32'hA5A5_A5A5, 4'hF);
      chk("t1_setup", {psel, penable, cmd_ready, rsp_valid}, {4'b0001, 3'b000});
      chk("t1_bus", {pwrite, paddr, pwdata, pstrb}, {1'b1, 32'h0000_0004, 32'hA5A5_A5A5, 4'hF});
      @(negedge clk);
      chk("t1_access", {psel, penable, rsp_valid}, {4'b0001, 1'b1, 1'b0});
      @(negedge clk);
      chk("t1_resp", {rsp_valid, psel, penable, rsp_err, rsp_rdata}, {1'b1, 4'b0, 1'b0, 2'b00, 32'h0});
      finish_rsp();

      // Read slave 2 with 3 wait cycles; other slaves ready / erroring are ignored
      pready  = 4'b1011;
      pslverr = 4'b0001;
      prdata  = {32'h0BAD_0BAD, 32'h1234_5678, 32'hFFFF_0000, 32'hDEAD_BEEF};
      issue(1'b0, 32'h8000_0010, 32'hFFFF_FFFF, 4'hF);
      chk("t2_setup", {psel, penable, pwrite, pstrb, paddr}, {4'b0100, 1'b0, 1'b0, 4'h0, 32'h8000_0010});
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("t2_access", {psel, penable, rsp_valid}, {4'b0100, 1'b1, 1'b0});
         if (i == 3) pready = 4'b1111;
      end
      @(negedge clk);
      chk("t2_resp", {rsp_valid, rsp_err, rsp_rdata, psel}, {1'b1, 2'b00, 32'h1234_5678, 4'b0});
      finish_rsp();

      // Write slave 1 with PSLVERR, response stalled 5 cycles
      pslverr = 4'b0010;
      issue(1'b1, 32'h4000_0008, 32'h1122_3344, 4'b0101);
      chk("t3_setup", {psel, pstrb}, {4'b0010, 4'b0101});
      @(negedge clk);
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         chk("t3_hold", {rsp_valid, rsp_err, rsp_rdata, cmd_ready, psel, penable},
             {1'b1, 2'b01, 32'h0, 1'b0, 4'b0, 1'b0});
         @(negedge clk);
      end
      finish_rsp();

      // Read slave 3 with PSLVERR: data forced to zero
      pslverr = 4'b1000;
      issue(1'b0, 32'hC000_0000, 32'h0, 4'hF);
      @(negedge clk);
      @(negedge clk);
      chk("t3b_resp", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 2'b01, 32'h0});
      finish_rsp();

      // Timeout: slave 0 never ready
      pslverr = 4'b0000;
      pready  = 4'b1110;
      issue(1'b0, 32'h0000_0020, 32'h0, 4'h0);
      count = 0;
      for (int i = 0; i < 40 && !rsp_valid; i++) begin
         @(negedge clk);
         if (penable && psel == 4'b0001) count++;
      end
      chk("t4_cycles", count, 16);
      chk("t4_resp", {rsp_valid, rsp_err, rsp_rdata, psel, penable}, {1'b1, 2'b10, 32'h0, 4'b0, 1'b0});
      finish_rsp();

      // pready on the 16th ACCESS cycle beats the timeout
      pready = 4'b1101;
      issue(1'b0, 32'h4000_0000, 32'h0, 4'h0);
      repeat (16) @(negedge clk);
      chk("t5_access16", {psel, penable}, {4'b0010, 1'b1});
      pready = 4'b1111;
      @(negedge clk);
      chk("t5_resp", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 2'b00, 32'hFFFF_0000});
      finish_rsp();

      // Reset in the middle of ACCESS
      pready = 4'b1110;
      issue(1'b1, 32'h0000_0040, 32'h55AA_55AA, 4'hF);
      @(negedge clk);
      chk("t6_access", {psel, penable}, {4'b0001, 1'b1});
      #2 rst = 1'b1;
      #1;
      chk("t6_async", {psel, penable, rsp_valid, cmd_ready, paddr}, {4'b0, 1'b0, 1'b0, 1'b0, 32'h0});
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("t6_release", {rsp_valid, cmd_ready}, 2'b01);
      pready = 4'hF;
      prdata[63:32] = 32'hCAFE_F00D;
      issue(1'b0, 32'h4000_0004, 32'h0, 4'h0);
      @(negedge clk);
      @(negedge clk);
      chk("t6_next", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 2'b00, 32'hCAFE_F00D});
      finish_rsp();

      // 3-slave instance: index 3 decodes to nothing
      b_cmd_valid = 1'b1; b_cmd_write = 1'b1; b_cmd_addr = 32'hC000_0000; b_cmd_wdata = 32'h1;
      @(negedge clk);
      b_cmd_valid = 1'b0;
      chk("t7_resp", {b_rsp_valid, b_rsp_err, b_rsp_rdata, b_penable}, {1'b1, 2'b11, 32'h0, 1'b0});
      b_rsp_ready = 1'b1;
      @(negedge clk);
      b_rsp_ready = 1'b0;
      chk("t7_nopsel", b_psel_seen, 1'b0);
      chk("t7_done", {b_rsp_valid, b_cmd_ready}, 2'b01);

      // 3-slave instance: valid index 2 still works
      b_prdata[95:64] = 32'h0000_0077;
      b_cmd_valid = 1'b1; b_cmd_write = 1'b0; b_cmd_addr = 32'h8000_0000;
      @(negedge clk);
      b_cmd_valid = 1'b0;
      chk("t8_setup", {b_psel, b_penable}, {3'b100, 1'b0});
      @(negedge clk);
      @(negedge clk);
      chk("t8_resp", {b_rsp_valid, b_rsp_err, b_rsp_rdata}, {1'b1, 2'b00, 32'h0000_0077});

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
